// File: rtl/pipe_pkg.sv
// Shared types for the RISC-V inter-stage pipeline registers: control/data
// bundle layouts, their widths, and the skid-buffer occupancy encoding.
package pipe_pkg;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] pc;
  } id_ex_data_t;

  localparam int CTRL_BUNDLE_W = $bits(ctrl_t);
  localparam int DATA_BUNDLE_W = $bits(id_ex_data_t);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state uses non-blocking (<=) so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with optional 2-entry skid
// buffer, flush-to-bubble and a saturating bubble-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_BUNDLE_W,
  parameter int DATA_W = DATA_BUNDLE_W,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  bubble_cnt,
  input  logic              clr_cnt
);

  logic              head_vld;
  logic [CTRL_W-1:0] head_ctrl;
  logic [DATA_W-1:0] head_data;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = head_vld && out_ready;
  assign out_valid = head_vld;
  // Dropped or stale entries must never look like live control downstream.
  assign out_ctrl  = head_vld ? head_ctrl : '0;
  assign out_data  = head_data;

  generate
    if (SKID == 1'b0) begin : g_single
      // Combinational pass-through: a draining head frees the slot this cycle.
      assign in_ready = !flush && (!head_vld || out_ready);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          head_vld <= 1'b0;
        end else if (flush) begin
          head_vld <= 1'b0;
        end else if (in_xfer) begin
          head_vld <= 1'b1;
        end else if (out_xfer) begin
          head_vld <= 1'b0;
        end
      end

      // NOTE: payload flops are reset because out_data must read zero out of reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          head_ctrl <= '0;
          head_data <= '0;
        end else if (in_xfer) begin
          head_ctrl <= in_ctrl;
          head_data <= in_data;
        end
      end
    end else begin : g_skid
      state_t            state_q;
      state_t            state_d;
      logic [CTRL_W-1:0] skid_ctrl;
      logic [DATA_W-1:0] skid_data;

      // Ready comes only from flops, breaking the cross-stage ready chain.
      assign in_ready = !flush && (state_q != TWO);
      assign head_vld = (state_q != EMPTY);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q <= EMPTY;
        end else begin
          state_q <= state_d;
        end
      end

      // NOTE: next-state gets a default first so no path can infer a latch.
      always_comb begin
        state_d = state_q;
        if (flush) begin
          state_d = EMPTY;
        end else begin
          unique case (state_q)
            EMPTY: if (in_xfer) state_d = ONE;
            ONE: begin
              if (in_xfer && !out_xfer)      state_d = TWO;
              else if (!in_xfer && out_xfer) state_d = EMPTY;
            end
            TWO:     if (out_xfer) state_d = ONE;
            default: state_d = EMPTY;
          endcase
        end
      end

      // Head only changes on a transfer, so a stalled output stays stable.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          head_ctrl <= '0;
          head_data <= '0;
          skid_ctrl <= '0;
          skid_data <= '0;
        end else if (!flush) begin
          if ((state_q == EMPTY && in_xfer) || (state_q == ONE && in_xfer && out_xfer)) begin
            head_ctrl <= in_ctrl;
            head_data <= in_data;
          end else if (state_q == ONE && in_xfer) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
          end else if (state_q == TWO && out_xfer) begin
            head_ctrl <= skid_ctrl;
            head_data <= skid_data;
          end
        end
      end
    end
  endgenerate

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (!head_vld),
    .clr  (clr_cnt),
    .count(bubble_cnt)
  );

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic parametrised pipeline stage register that replaces the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the 64-bit RISC-V pipeline. It carries a packed control bundle and a packed data bundle with a valid/ready handshake. It optionally provides a 2-entry skid buffer so back-pressure does not create a combinational ready path across stages. Flush inserts bubbles, and a saturating counter reports bubble cycles for performance analysis.

## Interface
- CTRL_W, default 7: width of the control bundle (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp[1:0]).
- DATA_W, default 271: width of the data bundle (rs1Data, rs2Data, imm at 64 bits each, plus rs1, rs2, rd at 5 bits each, plus pc at 64 bits).
- SKID, default 1: 0 selects a single register; 1 selects a 2-entry skid buffer.
- CNT_W, default 16: width of the bubble counter.
- clk, input, 1: clock. All state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: upstream holds a valid instruction.
- in_ready, output, 1: stage accepts this cycle.
- in_ctrl, input, CTRL_W: control bundle.
- in_data, input, DATA_W: data bundle.
- out_valid, output, 1: head entry valid.
- out_ready, input, 1: downstream accepts.
- out_ctrl, output, CTRL_W: head control bundle. Forced to all-zero when out_valid=0.
- out_data, output, DATA_W: head data bundle.
- flush, input, 1: synchronous kill of all held and incoming entries.
- bubble_cnt, output, CNT_W: saturating count of cycles with out_valid=0.
- clr_cnt, input, 1: synchronous clear of bubble_cnt.

## Operation
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- SKID=0:
  - One entry plus a valid flop.
  - in_ready = !out_valid || out_ready. This is a combinational pass-through.
  - On an input transfer, the entry loads and valid is set.
  - On an output transfer with no input transfer, valid is cleared.
- SKID=1:
  - Two entries (head, skid) and a state flop with states EMPTY, ONE, TWO.
  - in_ready = (state != TWO). It depends only on flops.
  - Transitions:
    - EMPTY + input transfer → ONE; input goes to head.
    - ONE + input transfer + output transfer → ONE; head reloads from input.
    - ONE + input transfer only → TWO; input goes to skid.
    - ONE + output transfer only → EMPTY.
    - TWO + output transfer → ONE; skid moves to head.
    - No transfer: hold.
- Flush:
  - All valids clear and state becomes EMPTY on the next edge.
  - in_ready is forced 0 during the flush cycle, so no input transfer occurs.
  - Flush overrides every simultaneous transfer.
  - Data registers keep their last values. Control of the dropped entries is never presented, because out_ctrl is masked.
- Bubble counter:
  - Increments each cycle with out_valid=0.
  - Saturates at 2^CNT_W−1.
  - clr_cnt has priority over increment.
- Data and control never change while out_valid && !out_ready. This stability is required.

## Timing
- Reset values:
  - out_valid=0, out_ctrl=0, out_data=0, bubble_cnt=0.
  - State EMPTY.
  - in_ready=1 for SKID=1. For SKID=0, in_ready=1 follows from out_valid=0.
- Latency: 1 cycle from an input transfer to out_valid when empty.
- Throughput: 1 transfer per cycle when out_ready is held high, for both SKID values.
- SKID=1: at most two transfers are accepted after out_ready falls; in_ready drops the cycle after TWO is entered.
- Reset asserted mid-operation:
  - All entries are discarded immediately and asynchronously.
  - Outputs take their reset values without waiting for clk.
- The bubble_cnt increment uses the pre-edge out_valid. The first cycle after reset counts as a bubble.

## Structure
- Package pipe_pkg holds:
  - the ctrl_t packed struct (CTRL_W fields);
  - the id_ex_data_t packed struct;
  - a localparam for each bundle width;
  - the state enum {EMPTY, ONE, TWO}.
- Sub-module sat_counter (CNT_W, inc, clr) holds the bubble counter.
- SKID selects its datapath by generate.

## Test plan
- Reset with in_valid=1 → out_valid=0, out_ctrl=0, bubble_cnt=0. One cycle after reset release, with in_data=0x…05, out_valid=1 and out_data=0x…05.
- SKID=1, streaming inputs 1,2,3,4 with out_ready=1 → outputs 1,2,3,4 on consecutive cycles, and in_ready stays 1.
- SKID=1, hold out_ready=0 while driving 1,2,3 → inputs 1 and 2 are accepted, in_ready=0 while 3 is offered, and out_data stays 1. Raising out_ready then yields 1,2,3 in order.
- Flush with state TWO and in_valid=1 → in_ready=0 that cycle. The next cycle gives out_valid=0, out_ctrl=0, and the entries are lost. The following input appears after 1 cycle.
- With CNT_W=4, idle for 20 cycles → bubble_cnt=15 and holds. clr_cnt pulse → next value 0, then 1.
- SKID=0, out_ready=0 while full → in_ready=0. Raising out_ready with in_valid=1 gives in_ready=1 in the same cycle and a simultaneous replace.
